// File: rtl/pmem_line_responder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pmem_line_responder_pkg : shared LC-3b memory-interface types       |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
package pmem_line_responder_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cacheline;
  typedef logic [3:0]   lc3b_pmem_cnt;

  typedef enum logic [1:0] {
    pmem_idle = 2'd0,
    pmem_wait = 2'd1,
    pmem_resp = 2'd2
  } lc3b_pmem_state;

  // Byte-offset bits within a 16-byte line.
  localparam int unsigned c_LINE_OFS_BITS = 4;

endpackage
`default_nettype wire

// File: rtl/pmem_line_responder_array.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pmem_line_array : single-port line storage, sync write, reg. read  |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module pmem_line_array
  import pmem_line_responder_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_we,
  input  logic                 i_re,
  input  logic [ADDR_BITS-1:0] i_idx,
  input  lc3b_cacheline        i_wdata,
  output lc3b_cacheline        o_rdata
);

  lc3b_cacheline r_mem [0:(1 << ADDR_BITS)-1];
  lc3b_cacheline r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  // Read register holds its value between reads; only it is reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/pmem_line_responder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pmem_line_responder : fixed-latency cacheline memory responder     |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module pmem_line_responder
  import pmem_line_responder_pkg::*;
#(
  parameter int unsigned LATENCY        = 4,
  parameter int unsigned LINE_ADDR_BITS = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_pmem_read,
  input  logic          i_pmem_write,
  input  lc3b_word      i_pmem_address,
  input  lc3b_cacheline i_pmem_wdata,
  output lc3b_cacheline o_pmem_rdata,
  output logic          o_pmem_resp
);

  localparam lc3b_pmem_cnt c_LATENCY  = lc3b_pmem_cnt'(LATENCY);
  localparam logic         c_ZERO_LAT = (LATENCY == 0);
  localparam int unsigned  c_IDX_LSB  = c_LINE_OFS_BITS;
  localparam int unsigned  c_IDX_MSB  = LINE_ADDR_BITS + c_LINE_OFS_BITS - 1;

  lc3b_pmem_state            r_state;
  lc3b_pmem_cnt              r_cnt;
  logic                      r_is_write;
  logic [LINE_ADDR_BITS-1:0] r_idx;
  lc3b_cacheline             r_wdata;
  logic                      r_resp;

  logic                      w_req;
  logic                      w_idle;
  logic                      w_commit;
  logic                      w_op_write;
  logic [LINE_ADDR_BITS-1:0] w_idx;
  lc3b_cacheline             w_wdata;
  logic                      w_we;
  logic                      w_re;
  logic                      w_unused_addr;

  assign w_req  = i_pmem_read | i_pmem_write;
  assign w_idle = (r_state == pmem_idle);

  // The array is accessed on the edge entering RESP; with zero latency that
  // edge is the acceptance edge, so the live request is used instead of latches.
  assign w_commit   = (w_idle && w_req && c_ZERO_LAT) ||
                      (r_state == pmem_wait && r_cnt == lc3b_pmem_cnt'(1));
  assign w_op_write = w_idle ? i_pmem_write : r_is_write;
  assign w_idx      = w_idle ? i_pmem_address[c_IDX_MSB:c_IDX_LSB] : r_idx;
  assign w_wdata    = w_idle ? i_pmem_wdata : r_wdata;
  assign w_we       = rst_n & w_commit & w_op_write;
  assign w_re       = w_commit & ~w_op_write;

  assign w_unused_addr = ^{i_pmem_address[15:c_IDX_MSB+1], i_pmem_address[c_IDX_LSB-1:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= pmem_idle;
      r_resp  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_resp <= 1'b0;
      unique case (r_state)
        pmem_idle: begin
          if (w_req) begin
            r_is_write <= i_pmem_write;
            r_idx      <= i_pmem_address[c_IDX_MSB:c_IDX_LSB];
            r_wdata    <= i_pmem_wdata;
            r_cnt      <= c_LATENCY;
            if (c_ZERO_LAT) begin
              r_state <= pmem_resp;
              r_resp  <= 1'b1;
            end else begin
              r_state <= pmem_wait;
            end
          end
        end
        pmem_wait: begin
          r_cnt <= r_cnt - lc3b_pmem_cnt'(1);
          if (r_cnt == lc3b_pmem_cnt'(1)) begin
            r_state <= pmem_resp;
            r_resp  <= 1'b1;
          end
        end
        pmem_resp: begin
          r_state <= pmem_idle;
        end
        default: begin
          r_state <= pmem_idle;
        end
      endcase
    end
  end

  pmem_line_array #(
    .ADDR_BITS (LINE_ADDR_BITS)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_idx   (w_idx),
    .i_wdata (w_wdata),
    .o_rdata (o_pmem_rdata)
  );

  assign o_pmem_resp = r_resp;

  // Simultaneous read and write is served as a write; flag its occurrence.
  cp_read_and_write: cover property (@(posedge clk) disable iff (!rst_n)
    (w_idle && i_pmem_read && i_pmem_write));

endmodule
`default_nettype wire

// File: doc/pmem_line_responder.md
Name: pmem_line_responder

Overview:
- Synthesizable physical-memory responder at the far end of the cacheline memory interface driven by the L2 cache.
- Accepts 128-bit line read/write requests.
- Models a fixed access latency, then returns a one-cycle response pulse.
- Backs the design in simulation and FPGA bring-up, and gives the cache controllers a deterministic-latency target.

Parameters:
- LATENCY, 4, wait cycles between request acceptance and response; legal range 0..15.
- LINE_ADDR_BITS, 8, index width of line storage (2^8 = 256 lines = 4 KB); address bits above [LINE_ADDR_BITS+3] are ignored, so addresses alias.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- pmem_read  in  1  line read request; held by initiator until pmem_resp.
- pmem_write  in  1  line write request; held by initiator until pmem_resp.
- pmem_address  in  16  byte address (lc3b_word); bits [3:0] ignored.
- pmem_wdata  in  128  write line (lc3b_cacheline); stable while pmem_write is high.
- pmem_rdata  out  128  read line; registered.
- pmem_resp  out  1  one-cycle completion pulse for read or write.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state <= IDLE; pmem_resp <= 0; pmem_rdata <= 0; wait counter <= 0.
  - Storage contents are NOT cleared; unwritten lines are undefined.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If pmem_read or pmem_write is high: latch op, line index (address[LINE_ADDR_BITS+3:4]) and wdata; cnt <= LATENCY.
  - Next state is WAIT if LATENCY > 0, else RESP.
  - If neither is high, stay in IDLE.
- Read and write both high: treated as a write. rdata is unchanged; the event is flagged by an assertion in simulation.
- WAIT: cnt decrements each cycle. When cnt == 1, next state is RESP. Exactly LATENCY cycles are spent in WAIT.
- Array access happens on the edge that enters RESP:
  - Write commits the latched wdata to the line.
  - Read loads pmem_rdata from the line.
- RESP: pmem_resp = 1 for exactly one cycle; next state is IDLE unconditionally.
- Timing: a request first visible in cycle T gets pmem_resp high in cycle T+1+LATENCY. pmem_resp is never high two cycles in a row.
- Protocol:
  - Inputs are sampled only in IDLE. Changes during WAIT/RESP are ignored; the latched copy is used.
  - The initiator drops or changes its request in the cycle after pmem_resp. IDLE in that cycle treats any request present as a new one.
  - Back-to-back requests are therefore spaced LATENCY+2 cycles apart.
- pmem_rdata:
  - Holds its value until the next read completes.
  - Unchanged by writes.
  - Valid in the pmem_resp cycle and afterwards.
- Read-after-write to the same line, back-to-back: returns the newly written data (the write commits before the next acceptance).
- Reset mid-operation (WAIT or RESP):
  - Abort to IDLE with no response pulse.
  - A pending write whose commit edge coincides with the rst_n=0 edge is dropped; reset has priority.
- Address aliasing: 0x0000 and 0x1000 (LINE_ADDR_BITS=8) hit the same line.
- Counter width is 4 bits.

Decomposition:
- Shared lc3b_types package additions:
  - enum lc3b_pmem_state {pmem_idle, pmem_wait, pmem_resp}.
  - typedef lc3b_pmem_cnt (logic [3:0]).
  - Reuse lc3b_word and lc3b_cacheline.
- Sub-module pmem_line_array: 2^LINE_ADDR_BITS x 128 single-port storage; synchronous write, registered read.
- pmem_line_responder keeps the FSM, counter and request latches.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles, then release -> pmem_resp=0 and pmem_rdata=0, state IDLE; no resp for 10 idle cycles.
- Write then read, LATENCY=4:
  - Write 0x0123_4567_89AB_CDEF_0011_2233_4455_6677 at 0x0230, request in cycle T -> resp only in cycle T+5.
  - Read 0x023F issued the cycle after that resp -> returns the same line with resp 5 cycles after acceptance.
- LATENCY=0: read request in cycle T -> resp in T+1. Hold read continuously -> resp in T+1, T+3, T+5 (never consecutive).
- Aliasing/offset: write line A to 0x0010, then read 0x1014 -> rdata = A. A subsequent write resp leaves rdata = A.
- Reset mid-write: write to 0x0040 (old content B), rst_n=0 during WAIT cycle 2 -> no resp; a later read of 0x0040 returns B.
- Input churn: change pmem_address from 0x0100 to 0x0200 during WAIT of a read -> data for 0x0100 returned. Read and write both high -> write performed and rdata unchanged.
